// File: rtl/tone_pkg.sv
// tone_pkg: note codes, sequencer states and the pattern step record shared by the tone sequencer
package tone_pkg;
  localparam int DUR_W = 8;
  localparam logic [2:0] NOTE_0 = 3'b000, NOTE_1 = 3'b001, NOTE_2 = 3'b010, NOTE_3 = 3'b011;
  localparam logic [2:0] NOTE_4 = 3'b100, NOTE_5 = 3'b101, NOTE_6 = 3'b110, NOTE_7 = 3'b111;
  typedef enum logic [2:0] {IDLE, FETCH, PLAY, GAP, ADVANCE, DONE} state_t;
  typedef struct packed {
    logic [2:0]       note;
    logic             rest;
    logic [DUR_W-1:0] dur;
  } step_t;
endpackage

// File: rtl/tone_sequencer_if.sv
// tone_sequencer_if: host pattern write port, transport controls and tone divider drive
interface tone_sequencer_if #(parameter int DEPTH = 16);
  localparam int AW = $clog2(DEPTH);
  logic                       i_wr_en;
  logic [AW-1:0]              i_wr_addr;
  logic [2:0]                 i_wr_note;
  logic                       i_wr_rest;
  logic [tone_pkg::DUR_W-1:0] i_wr_dur;
  logic                       i_start;
  logic                       i_stop;
  logic                       i_loop;
  logic [2:0]                 o_note_sel;
  logic                       o_div_reset;
  logic                       o_busy;
  logic [AW-1:0]              o_step;
  logic                       o_done;
  modport master (
    output i_wr_en, i_wr_addr, i_wr_note, i_wr_rest, i_wr_dur, i_start, i_stop, i_loop,
    input  o_note_sel, o_div_reset, o_busy, o_step, o_done
  );
  modport slave (
    input  i_wr_en, i_wr_addr, i_wr_note, i_wr_rest, i_wr_dur, i_start, i_stop, i_loop,
    output o_note_sel, o_div_reset, o_busy, o_step, o_done
  );
endinterface

// File: rtl/tone_sequencer_tick_prescaler.sv
// tick_prescaler: one-cycle tick every TICK_DIV clocks, restarted from zero by clr
module tick_prescaler #(
  parameter int TICK_DIV = 500000
) (
  input  logic inClk,
  input  logic reset,
  input  logic clr,
  output logic tick
);
  localparam int CW = $clog2(TICK_DIV);
  logic [CW-1:0] r_cnt;
  assign tick = r_cnt == CW'(TICK_DIV - 1);
  always_ff @(posedge inClk)
    r_cnt <= (reset || clr || tick) ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/tone_sequencer.sv
// tone_sequencer: steps through a stored melody, driving the tone divider's note select and reset
module tone_sequencer import tone_pkg::*; #(
  parameter int TICK_DIV  = 500000,
  parameter int DEPTH     = 16,
  parameter int GAP_TICKS = 1
) (
  input logic             inClk,
  input logic             reset,
  tone_sequencer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int GW = $clog2(GAP_TICKS + 2);
  step_t            r_mem [DEPTH];
  state_t           r_state, w_next;
  logic [AW-1:0]    r_step, w_step;
  logic [2:0]       r_note;
  logic             r_rest;
  logic [DUR_W-1:0] r_rem;
  logic [GW-1:0]    r_gap;
  logic             w_tick, w_clr, w_end, w_last;
  step_t            w_cur;
  logic [DUR_W-1:0] w_nxt_dur;
  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_pre (.inClk(inClk), .reset(reset), .clr(w_clr), .tick(w_tick));
  assign w_cur     = r_mem[r_step];
  assign w_nxt_dur = r_mem[r_step + 1'b1].dur;
  assign w_end     = w_tick && r_rem == DUR_W'(1);
  // the final note of a non-looping pass runs straight into ADVANCE with no trailing gap
  assign w_last    = r_step == AW'(DEPTH - 1) || (w_nxt_dur == '0 && !bus.i_loop);
  always_comb begin
    w_next = r_state;
    w_step = r_step;
    w_clr  = 1'b0;
    case (r_state)
      IDLE: if (bus.i_start) begin
        w_next = FETCH;
        w_step = '0;
      end
      FETCH: begin
        w_clr = 1'b1;
        if (w_cur.dur != '0) w_next = PLAY;
        else if (bus.i_loop && r_step != '0) w_step = '0;
        else w_next = DONE;
      end
      PLAY: if (w_end) begin
        w_next = (w_last || GAP_TICKS == 0) ? ADVANCE : GAP;
        w_clr  = !w_last && GAP_TICKS != 0;
      end
      GAP: if (w_tick && r_gap == GW'(1)) w_next = ADVANCE;
      ADVANCE: begin
        w_next = (r_step != AW'(DEPTH - 1) || bus.i_loop) ? FETCH : DONE;
        w_step = (w_next == FETCH) ? r_step + 1'b1 : r_step;
      end
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (bus.i_stop) begin
      w_next = IDLE;
      w_step = '0;
    end
  end
  always_ff @(posedge inClk) begin
    if (reset) begin
      r_state <= IDLE;
      r_step  <= '0;
      r_note  <= NOTE_0;
      r_rest  <= 1'b1;
      r_rem   <= '0;
      r_gap   <= '0;
    end else begin
      r_state <= w_next;
      r_step  <= w_step;
      if (r_state == FETCH && w_next == PLAY) begin
        r_note <= w_cur.note;
        r_rest <= w_cur.rest;
        r_rem  <= w_cur.dur;
      end else if (r_state == PLAY && w_tick) r_rem <= r_rem - 1'b1;
      if (r_state == PLAY && w_next == GAP) r_gap <= GW'(GAP_TICKS);
      else if (r_state == GAP && w_tick) r_gap <= r_gap - 1'b1;
    end
  end
  always_ff @(posedge inClk)
    if (bus.i_wr_en) r_mem[bus.i_wr_addr] <= '{note: bus.i_wr_note, rest: bus.i_wr_rest, dur: bus.i_wr_dur};
  assign bus.o_note_sel  = r_note;
  assign bus.o_div_reset = r_state != PLAY || r_rest;
  assign bus.o_busy      = r_state != IDLE;
  assign bus.o_step      = r_step;
  assign bus.o_done      = r_state == DONE;
endmodule

// File: tb/tb_tone_sequencer.sv
// tb_tone_sequencer: directed and randomized melodies checked cycle by cycle against a step-level reference trace
module tb_tone_sequencer;
  localparam int TD = 4, GT = 1, N = 16;
  logic inClk = 1'b0;
  logic reset = 1'b1;
  always #5 inClk = ~inClk;
  tone_sequencer_if #(.DEPTH(N)) bus ();
  tone_sequencer #(.TICK_DIV(TD), .DEPTH(N), .GAP_TICKS(GT)) dut (.inClk(inClk), .reset(reset), .bus(bus));

  // model pattern memory and expected per-cycle trace {busy, done, div_reset, note[2:0], step[3:0]}
  logic [2:0] m_note [N];
  logic       m_rest [N];
  int         m_dur  [N];
  logic [9:0] exp_q [$];
  logic [2:0] cur_note;
  bit         g_lp, g_fin;
  int         g_lo, g_wr, g_wa;
  logic [2:0] g_wn;
  int         n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [9:0] got, input logic [9:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got busy/done/divrst/note/step=%b/%b/%b/%b/%0d want %b/%b/%b/%b/%0d", tag,
                  got[9], got[8], got[7], got[6:4], got[3:0], want[9], want[8], want[7], want[6:4], want[3:0]);
  endtask

  function automatic logic [9:0] obs();
    return {bus.o_busy, bus.o_done, bus.o_div_reset, bus.o_note_sel, bus.o_step};
  endfunction

  function automatic bit lp_at(input int idx);
    return g_lp && !(g_lo >= 0 && idx >= g_lo);
  endfunction

  task automatic upd(input int idx);
    if (g_wr >= 0 && idx > g_wr) m_note[g_wa] = g_wn;
  endtask

  task automatic emit(input bit d, input bit r, input int s);
    exp_q.push_back({1'b1, d, r, cur_note, 4'(s)});
  endtask

  task automatic cfg(input bit lp, input int lo, input int wr, input int wa, input logic [2:0] wn);
    g_lp = lp; g_lo = lo; g_wr = wr; g_wa = wa; g_wn = wn;
  endtask

  // expected trace built step by step: fetch, D ticks of note, optional gap, advance
  task automatic gen(input int maxc);
    int s = 0, ai;
    bit last;
    exp_q.delete();
    g_fin = 1'b0;
    while (!g_fin && exp_q.size() < maxc) begin
      upd(exp_q.size());
      emit(1'b0, 1'b1, s);
      if (m_dur[s] == 0) begin
        if (lp_at(exp_q.size() - 1) && s != 0) s = 0;
        else begin emit(1'b1, 1'b1, s); g_fin = 1'b1; end
      end else begin
        cur_note = m_note[s];
        repeat (m_dur[s] * TD) emit(1'b0, m_rest[s], s);
        ai = exp_q.size() - 1;
        upd(ai);
        last = s == N - 1 || (m_dur[(s + 1) % N] == 0 && !lp_at(ai));
        if (!last) repeat (GT * TD) emit(1'b0, 1'b1, s);
        emit(1'b0, 1'b1, s);
        ai = exp_q.size() - 1;
        if (s < N - 1) s++;
        else if (lp_at(ai)) s = 0;
        else begin emit(1'b1, 1'b1, s); g_fin = 1'b1; end
      end
    end
  endtask

  task automatic load();
    for (int i = 0; i < N; i++) begin
      @(negedge inClk);
      bus.i_wr_en = 1'b1; bus.i_wr_addr = 4'(i);
      bus.i_wr_note = m_note[i]; bus.i_wr_rest = m_rest[i]; bus.i_wr_dur = 8'(m_dur[i]);
    end
    @(negedge inClk);
    bus.i_wr_en = 1'b0;
  endtask

  // kind: 0 run to completion, 1 stop (with a colliding start) at cycle at, 2 reset at cycle at
  task automatic run(input int kind_in, input int at_in);
    int n, kind, at;
    n = exp_q.size(); kind = kind_in; at = at_in;
    if (g_wr >= 0 && g_wr < n && at < g_wr) at = g_wr;
    if (!g_fin && (kind == 0 || at >= n)) begin kind = 1; at = n - 1; end
    if (kind != 0 && at >= n) kind = 0;
    @(negedge inClk);
    bus.i_loop = g_lp; bus.i_start = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge inClk);
      bus.i_start = 1'b0; bus.i_wr_en = 1'b0;
      chk("seq", obs(), exp_q[i]);
      if (i == g_lo) bus.i_loop = 1'b0;
      if (i == g_wr) begin
        bus.i_wr_en = 1'b1; bus.i_wr_addr = 4'(g_wa); bus.i_wr_note = g_wn;
        bus.i_wr_rest = m_rest[g_wa]; bus.i_wr_dur = 8'(m_dur[g_wa]);
      end
      if (kind != 0 && i == at) begin
        if (kind == 1) begin bus.i_stop = 1'b1; bus.i_start = 1'b1; end
        else reset = 1'b1;
        @(negedge inClk);
        bus.i_wr_en = 1'b0;
        cur_note = (kind == 2) ? 3'b000 : exp_q[i][6:4];
        if (kind == 1) chk("stop", obs(), {3'b001, cur_note, 4'd0});
        else chk("reset", obs(), {3'b001, cur_note, 4'd0});
        bus.i_stop = 1'b0; bus.i_start = 1'b0; reset = 1'b0;
        @(negedge inClk);
        chk("idle_after_abort", obs(), {3'b001, cur_note, 4'd0});
        return;
      end
    end
    @(negedge inClk);
    bus.i_wr_en = 1'b0;
    chk("idle_after_done", obs(), {3'b001, cur_note, exp_q[n - 1][3:0]});
  endtask

  task automatic base_pat();
    for (int i = 0; i < N; i++) begin
      m_note[i] = 3'($urandom); m_rest[i] = 1'($urandom); m_dur[i] = $urandom_range(0, 3);
    end
    m_note[0] = 3'b010; m_rest[0] = 1'b0; m_dur[0] = 2;
    m_note[1] = 3'b101; m_rest[1] = 1'b0; m_dur[1] = 1;
    m_dur[2] = 0;
  endtask

  initial begin
    bus.i_wr_en = 1'b0; bus.i_wr_addr = '0; bus.i_wr_note = '0; bus.i_wr_rest = 1'b0; bus.i_wr_dur = '0;
    bus.i_start = 1'b0; bus.i_stop = 1'b0; bus.i_loop = 1'b0;
    repeat (3) @(negedge inClk);
    chk("reset_state", obs(), {3'b001, 3'b000, 4'd0});
    reset = 1'b0;
    cur_note = 3'b000;
    // two-note melody, single pass, then looping with loop dropped after three passes
    base_pat(); load();
    cfg(0, -1, -1, 0, 0); gen(400); run(0, 0);
    cfg(1, 75, -1, 0, 0); gen(400); run(0, 0);
    // empty pattern, with and without loop
    m_dur[0] = 0; load();
    cfg(0, -1, -1, 0, 0); gen(400); run(0, 0);
    cfg(1, -1, -1, 0, 0); gen(400); run(0, 0);
    // stop in the middle of step 1
    base_pat(); load();
    cfg(0, -1, -1, 0, 0); gen(400); run(1, 16);
    // sixteen one-tick steps, rests on odd steps
    for (int i = 0; i < N; i++) begin m_note[i] = 3'($urandom); m_rest[i] = 1'(i % 2); m_dur[i] = 1; end
    load();
    cfg(0, -1, -1, 0, 0); gen(400); run(0, 0);
    cfg(1, -1, -1, 0, 0); gen(250); run(1, 240);
    // rewrite entry 0 while it plays, then reset mid-play and replay the retained pattern
    base_pat(); load();
    cfg(1, 60, 3, 0, 3'b111); gen(400); run(0, 0);
    cfg(1, -1, -1, 0, 0); gen(400); run(2, 30);
    cfg(0, -1, -1, 0, 0); gen(400); run(0, 0);
    for (int it = 0; it < 40; it++) begin
      if (it == 0 || $urandom_range(0, 1) == 1) begin
        int len = $urandom_range(0, N);
        for (int i = 0; i < N; i++) begin
          m_note[i] = 3'($urandom); m_rest[i] = 1'($urandom);
          m_dur[i] = (i < len) ? $urandom_range(1, 3) : (i == len ? 0 : $urandom_range(0, 3));
        end
        load();
      end
      cfg(1'($urandom), $urandom_range(0, 1) == 1 ? $urandom_range(10, 200) : -1,
          $urandom_range(0, 1) == 1 ? $urandom_range(0, 60) : -1, $urandom_range(0, N - 1), 3'($urandom));
      gen(400);
      run($urandom_range(0, 2), $urandom_range(0, 300));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/tone_sequencer.md
Name: tone_sequencer

Overview:
- Plays a programmable melody by driving the note-select code and reset of the existing switch-selected tone clock divider.
- Holds up to DEPTH steps; each step is {note, rest flag, duration}. Steps advance on a prescaled time tick.
- Sits between the board controls/host write port and the tone divider. The divider's note input and reset are taken from this block instead of SW[3:1] and the board reset.

Parameters:
- TICK_DIV, 500000: inClk cycles per duration tick (10 ms at 50 MHz). Must be ≥ 2.
- DEPTH, 16: number of pattern steps. Must be a power of 2.
- DUR_W, 8: duration field width, in ticks.
- GAP_TICKS, 1: silent ticks inserted after every non-final note. 0 disables the gap.

Ports:
- inClk  in  1  system clock
- reset  in  1  synchronous, active-high
- wr_en  in  1  write the pattern entry at wr_addr this cycle
- wr_addr  in  log2(DEPTH)  entry index
- wr_note  in  3  note code, same encoding as the divider select (000 = lowest … 111 = highest)
- wr_rest  in  1  1 = silent step
- wr_dur  in  DUR_W  step length in ticks; 0 = end-of-pattern marker
- start  in  1  level; sampled only in IDLE
- stop  in  1  level; abort from any state
- loop  in  1  at end-of-pattern, restart at step 0 instead of finishing
- note_sel  out  3  to divider note select
- div_reset  out  1  to divider reset; 1 = silent
- busy  out  1  1 in every state except IDLE
- step  out  log2(DEPTH)  index of the step currently playing
- done  out  1  one-cycle pulse on normal completion

Behaviour:
- Reset: state IDLE; note_sel=0, div_reset=1, busy=0, step=0, done=0; prescaler and duration counter cleared. Pattern memory is NOT cleared; its contents after power-up are undefined.
- Pattern memory: register array with combinational read. A write lands at the clock edge. Writes are allowed in any state.
  - Writing the entry currently playing does not change the note in progress.
  - The new value is used the next time that entry is fetched.
- IDLE: if start=1 and stop=0 → FETCH with step=0.
- FETCH (one cycle): read entry[step].
  - dur=0: if loop=1 and step≠0 → step=0, stay in FETCH. Otherwise → DONE.
  - dur≠0: latch note_sel, remaining=dur, prescaler=0. div_reset = rest flag. → PLAY.
- PLAY: the prescaler counts 0…TICK_DIV-1 and emits a tick at TICK_DIV-1. Each tick decrements remaining. On the tick where remaining=1:
  - last step (step=DEPTH-1, or next entry has dur=0 and loop=0): → ADVANCE directly, no gap.
  - otherwise, GAP_TICKS>0: → GAP with div_reset=1 and gap counter = GAP_TICKS.
  - otherwise: → ADVANCE.
- GAP: count GAP_TICKS ticks with div_reset=1, then → ADVANCE.
- ADVANCE (one cycle):
  - step=DEPTH-1 → if loop=1, step=0 → FETCH; otherwise → DONE.
  - else step+1 → FETCH.
- DONE (one cycle): done=1, div_reset=1, → IDLE.
- Note timing: a note step of dur D holds div_reset=0 for exactly D·TICK_DIV cycles.
- Start latency: start sampled at edge n; FETCH is active in cycle n+1; note_sel/div_reset are valid from edge n+2.
- stop: wins over everything, including a simultaneous start or end-of-pattern. On the next edge: state=IDLE, div_reset=1, step=0, no done pulse.
- start while busy: ignored. loop is sampled live at each end-of-pattern decision.
- Empty pattern (entry 0 dur=0): FETCH→DONE. done pulses at edge n+2 and div_reset never deasserts. This holds even when loop=1; the stay-in-FETCH rule requires step≠0, so there is no infinite FETCH.
- reset mid-operation: identical to power-up reset, except pattern contents are retained.

Decomposition:
- Shared package tone_pkg:
  - note code constants NOTE_0..NOTE_7 (3'b000..3'b111), the divider's half-period table encoding;
  - state enum {IDLE, FETCH, PLAY, GAP, ADVANCE, DONE};
  - step struct {note[2:0], rest, dur[DUR_W-1:0]}.
- Sub-module tick_prescaler(inClk, reset, clr, tick), parameter TICK_DIV. It is cleared by FETCH and when GAP is entered.

Test Plan:
All cases use TICK_DIV=4 and GAP_TICKS=1.
1. Pattern {(3'b010,dur 2),(3'b101,dur 1),(dur 0)}, loop=0, start pulse.
   - note_sel=010 with div_reset=0 for 8 cycles, then 4 cycles div_reset=1 (gap).
   - Then note_sel=101 for 4 cycles; done pulses once; busy falls; total edges as computed from the FSM.
2. Same pattern, loop=1.
   - After step 1, step returns to 0 with no done pulse; sequence repeats three times.
   - Deassert loop → done after the current pass.
3. Entry 0 dur=0 → done at edge n+2; div_reset stays 1 throughout; busy high for exactly 2 cycles.
4. Assert stop mid-PLAY of step 1 → next edge: IDLE, div_reset=1, step=0, done=0. A start asserted in the same cycle as stop is ignored.
5. All 16 entries dur=1, rest on odd steps, loop=0.
   - div_reset=1 during odd steps; step wraps 15→DONE, not 0.
   - Repeat with loop=1: step 15→0.
6. During step 0 playback, rewrite entry 0 note to 111 → current note unchanged. Next loop pass plays 111. Assert reset mid-play → outputs return to reset values and the pattern is retained (replay matches).
